apb_rr_arbiter: RTL and testbench

//  Round-robin arbiter sharing one APB master port among MASTER_PORTS core-side APB masters.

---
 rtl/apb_rr_arbiter_if.sv | 31 +++
 rtl/apb_rr_arbiter.sv | 157 +++++++++++++++
 tb/tb_apb_rr_arbiter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/apb_rr_arbiter_if.sv
// APB bundle for apb_rr_arbiter: MASTER_PORTS packed core-side ports plus one interconnect-side port.
// slave = the arbiter's view; master = the surrounding cores and interconnect.
interface apb_rr_arbiter_if #(
  parameter int BUS_WIDTH    = 16,
  parameter int MASTER_PORTS = 4
);
  logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PADDR;
  logic [MASTER_PORTS-1:0]           S_PWRITE;
  logic [MASTER_PORTS-1:0]           S_PSELx;
  logic [MASTER_PORTS-1:0]           S_PENABLE;
  logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PWDATA;
  logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PRDATA;
  logic [MASTER_PORTS-1:0]           S_PREADY;
  logic [BUS_WIDTH-1:0]              M_PADDR;
  logic                              M_PWRITE;
  logic                              M_PSELx;
  logic                              M_PENABLE;
  logic [BUS_WIDTH-1:0]              M_PWDATA;
  logic [BUS_WIDTH-1:0]              M_PRDATA;
  logic                              M_PREADY;

  modport slave (
    input  S_PADDR, S_PWRITE, S_PSELx, S_PENABLE, S_PWDATA, M_PRDATA, M_PREADY,
    output S_PRDATA, S_PREADY, M_PADDR, M_PWRITE, M_PSELx, M_PENABLE, M_PWDATA
  );

  modport master (
    output S_PADDR, S_PWRITE, S_PSELx, S_PENABLE, S_PWDATA, M_PRDATA, M_PREADY,
    input  S_PRDATA, S_PREADY, M_PADDR, M_PWRITE, M_PSELx, M_PENABLE, M_PWDATA
  );
endinterface

// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter sharing one APB port among MASTER_PORTS masters, locking each SETUP/ACCESS transfer.
// Optional ACCESS-phase timeout is compiled in when APB_ARB_TIMEOUT_EN is defined.
module apb_rr_arbiter #(
  parameter int BUS_WIDTH      = 16,
  parameter int MASTER_PORTS   = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  apb_rr_arbiter_if.slave         bus,
  output logic [MASTER_PORTS-1:0] arb_grant,
  output logic                    arb_timeout
);
  localparam int IDX_W = $clog2(MASTER_PORTS);
  localparam logic [BUS_WIDTH-1:0] TIMEOUT_DATA = BUS_WIDTH'(16'hDEAD);
  localparam logic [MASTER_PORTS-1:0] ONE_HOT_0 = {{(MASTER_PORTS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t                  state_r;
  logic [IDX_W-1:0]        gidx_r;
  logic [IDX_W-1:0]        last_gidx_r;
  logic [MASTER_PORTS-1:0] grant_r;
  logic                    psel_r;
  logic                    penable_r;
  logic [IDX_W-1:0]        pick_s;
  logic                    sel_held_s;
  logic                    timeout_s;
  logic                    complete_s;
  logic                    unused_s;

  // Nearest requester after 'last' wins; 'last' itself is tried last.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [MASTER_PORTS-1:0] req,
                                               input logic [IDX_W-1:0] last);
    logic [IDX_W-1:0] sel;
    int               cand;
    sel = last;
    for (int k = MASTER_PORTS; k >= 1; k--) begin
      cand = (int'(last) + k) % MASTER_PORTS;
      sel  = req[cand] ? IDX_W'(cand) : sel;
    end
    return sel;
  endfunction

  assign pick_s     = rr_pick(bus.S_PSELx, last_gidx_r);
  assign sel_held_s = bus.S_PSELx[gidx_r];

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] cnt_r;
  assign timeout_s = (state_r == ST_ACCESS) && sel_held_s && !bus.M_PREADY &&
                     (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
  assign unused_s  = ^bus.S_PENABLE;
`else
  assign timeout_s = 1'b0;
  assign unused_s  = ^{bus.S_PENABLE, (TIMEOUT_CYCLES > 32'sd0)};
`endif

  assign complete_s = (state_r == ST_ACCESS) && sel_held_s && (bus.M_PREADY || timeout_s);

  // Transfer FSM: grant, phase timing and rotating priority pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      gidx_r      <= '0;
      last_gidx_r <= IDX_W'(MASTER_PORTS - 1);
      grant_r     <= '0;
      psel_r      <= 1'b0;
      penable_r   <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
      cnt_r       <= '0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (|bus.S_PSELx) begin
            gidx_r    <= pick_s;
            grant_r   <= ONE_HOT_0 << pick_s;
            psel_r    <= 1'b1;
            penable_r <= 1'b0;
            state_r   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (!sel_held_s) begin
            last_gidx_r <= gidx_r;
            grant_r     <= '0;
            psel_r      <= 1'b0;
            penable_r   <= 1'b0;
            state_r     <= ST_IDLE;
          end else begin
            penable_r <= 1'b1;
            state_r   <= ST_ACCESS;
`ifdef APB_ARB_TIMEOUT_EN
            cnt_r     <= '0;
`endif
          end
        end
        ST_ACCESS: begin
          // Completion, forced timeout and a dropped PSEL all end the transfer the same way.
          if (!sel_held_s || bus.M_PREADY || timeout_s) begin
            last_gidx_r <= gidx_r;
            grant_r     <= '0;
            psel_r      <= 1'b0;
            penable_r   <= 1'b0;
            state_r     <= ST_IDLE;
          end else begin
`ifdef APB_ARB_TIMEOUT_EN
            cnt_r <= cnt_r + CNT_W'(1);
`endif
          end
        end
        default: begin
          grant_r   <= '0;
          psel_r    <= 1'b0;
          penable_r <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

  // Response routing: only the granted master ever sees PREADY/PRDATA.
  always_comb begin
    bus.S_PREADY = '0;
    bus.S_PRDATA = '0;
    if (complete_s) begin
      bus.S_PREADY[gidx_r] = 1'b1;
      bus.S_PRDATA[int'(gidx_r)*BUS_WIDTH +: BUS_WIDTH] = timeout_s ? TIMEOUT_DATA : bus.M_PRDATA;
    end else begin
      bus.S_PREADY = '0;
    end
  end

  // Request mux toward the interconnect; forced to zero while idle.
  always_comb begin
    bus.M_PADDR  = '0;
    bus.M_PWRITE = 1'b0;
    bus.M_PWDATA = '0;
    if (psel_r) begin
      bus.M_PADDR  = bus.S_PADDR[int'(gidx_r)*BUS_WIDTH +: BUS_WIDTH];
      bus.M_PWRITE = bus.S_PWRITE[gidx_r];
      bus.M_PWDATA = bus.S_PWDATA[int'(gidx_r)*BUS_WIDTH +: BUS_WIDTH];
    end else begin
      bus.M_PADDR = '0;
    end
  end

  assign bus.M_PSELx   = psel_r;
  assign bus.M_PENABLE = penable_r & ~timeout_s;
  assign arb_grant     = grant_r;
  assign arb_timeout   = timeout_s;
endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Directed bench for apb_rr_arbiter: inputs driven and outputs checked on the falling clock edge.
module tb_apb_rr_arbiter;
  localparam int BW = 16;
  localparam int MP = 4;
`ifdef APB_ARB_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 255;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [MP-1:0] arb_grant;
  logic          arb_timeout;
  int            n_checks = 0;
  int            n_fail = 0;
  int            pulses;

  apb_rr_arbiter_if #(.BUS_WIDTH(BW), .MASTER_PORTS(MP)) bus ();

  apb_rr_arbiter #(.BUS_WIDTH(BW), .MASTER_PORTS(MP), .TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .arb_grant   (arb_grant),
    .arb_timeout (arb_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    bus.S_PADDR   = '0;
    bus.S_PWRITE  = '0;
    bus.S_PSELx   = '0;
    bus.S_PENABLE = '0;
    bus.S_PWDATA  = '0;
    bus.M_PRDATA  = '0;
    bus.M_PREADY  = 1'b0;

    // Reset state
    step(); #1;
    chk("rst_grant", 64'(arb_grant), 64'h0);
    chk("rst_psel", 64'(bus.M_PSELx), 64'h0);
    chk("rst_penable", 64'(bus.M_PENABLE), 64'h0);
    chk("rst_paddr", 64'(bus.M_PADDR), 64'h0);
    chk("rst_spready", 64'(bus.S_PREADY), 64'h0);
    chk("rst_sprdata", bus.S_PRDATA, 64'h0);
    chk("rst_timeout", 64'(arb_timeout), 64'h0);

    // Single master m1 read of 0x00C0, zero wait states
    step(); reset = 1'b1;
    bus.S_PADDR[1*BW +: BW] = 16'h00C0;
    bus.S_PSELx = 4'b0010;
    #1 chk("t1_idle_grant", 64'(arb_grant), 64'h0);
    step();
    bus.M_PREADY = 1'b1;
    bus.M_PRDATA = 16'h1234;
    #1;
    chk("t1_setup_grant", 64'(arb_grant), 64'h2);
    chk("t1_setup_psel", 64'(bus.M_PSELx), 64'h1);
    chk("t1_setup_penable", 64'(bus.M_PENABLE), 64'h0);
    chk("t1_setup_paddr", 64'(bus.M_PADDR), 64'h00C0);
    chk("t1_setup_pwrite", 64'(bus.M_PWRITE), 64'h0);
    chk("t1_setup_noready", 64'(bus.S_PREADY), 64'h0);
    step(); #1;
    chk("t1_access_penable", 64'(bus.M_PENABLE), 64'h1);
    chk("t1_access_spready", 64'(bus.S_PREADY), 64'h2);
    chk("t1_access_sprdata", bus.S_PRDATA, 64'h0000_0000_1234_0000);
    step();
    bus.S_PSELx = 4'b0000;
    #1;
    chk("t1_idle_grant2", 64'(arb_grant), 64'h0);
    chk("t1_idle_psel", 64'(bus.M_PSELx), 64'h0);
    chk("t1_idle_spready", 64'(bus.S_PREADY), 64'h0);
    bus.M_PREADY = 1'b0;

    // All four request continuously from reset: order 0,1,2,3,0
    reset = 1'b0;
    step();
    reset = 1'b1;
    bus.S_PADDR = {16'h0D03, 16'h0C02, 16'h0B01, 16'h0A00};
    bus.S_PSELx = 4'b1111;
    bus.M_PREADY = 1'b1;
    bus.M_PRDATA = 16'h0077;
    #1 chk("t2_idle0", 64'(arb_grant), 64'h0);
    for (int t = 0; t < 5; t++) begin
      step(); #1;
      chk("t2_setup_grant", 64'(arb_grant), 64'(4'b0001 << (t % 4)));
      chk("t2_onehot", 64'($countones(arb_grant)), 64'd1);
      chk("t2_paddr", 64'(bus.M_PADDR), 64'(16'h0A00 + 16'h0101 * (t % 4)));
      step(); #1;
      chk("t2_access_spready", 64'(bus.S_PREADY), 64'(4'b0001 << (t % 4)));
      chk("t2_access_onehot", 64'($countones(arb_grant)), 64'd1);
      step(); #1;
      chk("t2_idle_grant", 64'(arb_grant), 64'h0);
    end

    // m2 writes 0xBEEF to 0x00B1 with 3 wait states
    bus.S_PSELx = 4'b0100;
    bus.S_PADDR[2*BW +: BW] = 16'h00B1;
    bus.S_PWRITE[2] = 1'b1;
    bus.S_PWDATA[2*BW +: BW] = 16'hBEEF;
    bus.M_PREADY = 1'b0;
    step(); #1;
    chk("t3_setup_grant", 64'(arb_grant), 64'h4);
    chk("t3_setup_paddr", 64'(bus.M_PADDR), 64'h00B1);
    chk("t3_setup_pwrite", 64'(bus.M_PWRITE), 64'h1);
    chk("t3_setup_pwdata", 64'(bus.M_PWDATA), 64'hBEEF);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      bus.M_PREADY = (i == 3);
      #1;
      chk("t3_penable", 64'(bus.M_PENABLE), 64'h1);
      chk("t3_pwdata", 64'(bus.M_PWDATA), 64'hBEEF);
      chk("t3_timeout", 64'(arb_timeout), 64'h0);
      chk("t3_spready", 64'(bus.S_PREADY), (i == 3) ? 64'h4 : 64'h0);
      pulses += int'(bus.S_PREADY[2]);
    end
    step();
    bus.S_PSELx = 4'b0000;
    bus.M_PREADY = 1'b0;
    #1;
    chk("t3_pulse_count", 64'(pulses), 64'd1);
    chk("t3_idle_penable", 64'(bus.M_PENABLE), 64'h0);
    chk("t3_idle_pwdata", 64'(bus.M_PWDATA), 64'h0);

    // Reset during ACCESS, then master 0 first
    bus.S_PSELx = 4'b0010;
    step(); #1 chk("t4_setup_grant", 64'(arb_grant), 64'h2);
    step(); #1 chk("t4_access_penable", 64'(bus.M_PENABLE), 64'h1);
    #1 reset = 1'b0;
    bus.M_PREADY = 1'b1;
    #1;
    chk("t4_rst_grant", 64'(arb_grant), 64'h0);
    chk("t4_rst_psel", 64'(bus.M_PSELx), 64'h0);
    chk("t4_rst_penable", 64'(bus.M_PENABLE), 64'h0);
    chk("t4_rst_paddr", 64'(bus.M_PADDR), 64'h0);
    chk("t4_rst_spready", 64'(bus.S_PREADY), 64'h0);
    step();
    reset = 1'b1;
    bus.S_PSELx = 4'b1111;
    bus.M_PREADY = 1'b0;
    #1 chk("t4_idle_grant", 64'(arb_grant), 64'h0);
    step(); #1;
    chk("t4_first_grant", 64'(arb_grant), 64'h1);
    chk("t4_first_paddr", 64'(bus.M_PADDR), 64'h0A00);
    step();
    bus.M_PREADY = 1'b1;
    bus.M_PRDATA = 16'h5A5A;
    #1;
    chk("t4_spready", 64'(bus.S_PREADY), 64'h1);
    chk("t4_sprdata", bus.S_PRDATA, 64'h0000_0000_0000_5A5A);
    step();
    bus.S_PSELx = 4'b1001;
    bus.M_PREADY = 1'b0;
    #1 chk("t4_idle_after", 64'(arb_grant), 64'h0);

    // Granted m3 drops PSEL in SETUP; pending m0 follows
    step();
    #1 chk("t5_setup_grant", 64'(arb_grant), 64'h8);
    bus.S_PSELx = 4'b0001;
    bus.M_PREADY = 1'b1;
    #1 chk("t5_setup_spready", 64'(bus.S_PREADY), 64'h0);
    step(); #1;
    chk("t5_abort_grant", 64'(arb_grant), 64'h0);
    chk("t5_abort_psel", 64'(bus.M_PSELx), 64'h0);
    chk("t5_abort_spready", 64'(bus.S_PREADY), 64'h0);
    bus.M_PREADY = 1'b0;
    step(); #1 chk("t5_next_grant", 64'(arb_grant), 64'h1);
    step();
    bus.M_PREADY = 1'b1;
    #1 chk("t5_m0_spready", 64'(bus.S_PREADY), 64'h1);
    step();
    bus.S_PSELx = 4'b0000;
    bus.M_PREADY = 1'b0;
    #1 chk("t5_idle", 64'(arb_grant), 64'h0);

`ifdef APB_ARB_TIMEOUT_EN
    // ACCESS timeout after 8 cycles with PREADY stuck low
    bus.S_PSELx = 4'b0010;
    step(); #1 chk("t6_setup_grant", 64'(arb_grant), 64'h2);
    for (int k = 1; k <= 8; k++) begin
      step(); #1;
      chk("t6_timeout", 64'(arb_timeout), (k == 8) ? 64'h1 : 64'h0);
      chk("t6_spready", 64'(bus.S_PREADY), (k == 8) ? 64'h2 : 64'h0);
      chk("t6_penable", 64'(bus.M_PENABLE), (k == 8) ? 64'h0 : 64'h1);
    end
    chk("t6_sprdata", bus.S_PRDATA, 64'h0000_0000_DEAD_0000);
    step();
    bus.S_PSELx = 4'b0000;
    #1;
    chk("t6_idle_timeout", 64'(arb_timeout), 64'h0);
    chk("t6_idle_grant", 64'(arb_grant), 64'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
